// File: rtl/proc_control_unit_if.sv
// proc_control_unit_if
//   Bundles the controller's pin-side inputs (run, din) and its datapath
//   control outputs into one port.
//   master : the controller (drives ir, enables, bus_sel, alu_op, busy, done)
//   slave  : the datapath / pin side (drives run, din)
interface proc_control_unit_if;
    logic       run;      // start request, sampled in IDLE
    logic [8:0] din;      // instruction at fetch, immediate source otherwise
    logic [8:0] ir;       // instruction register
    logic [7:0] r_in;     // one-hot GPR write enable
    logic       r_in_a;   // A register write enable
    logic       r_in_g;   // G register write enable
    logic       r_in_h;   // H register write enable
    logic [3:0] bus_sel;  // 0-7 Rn, 8 G, 9 sign-extended din
    logic [2:0] alu_op;   // opcode forwarded to the ALU
    logic       busy;     // high in T1-T3
    logic       done;     // high in the final micro-step

    modport master (
        input  run, din,
        output ir, r_in, r_in_a, r_in_g, r_in_h, bus_sel, alu_op, busy, done
    );

    modport slave (
        output run, din,
        input  ir, r_in, r_in_a, r_in_g, r_in_h, bus_sel, alu_op, busy, done
    );
endinterface

// File: rtl/proc_control_unit.sv
// proc_control_unit
//   Sequencing controller for the 16-bit processor datapath. Fetches a 9-bit
//   instruction from din into ir when run is seen in IDLE, then steps through
//   micro-steps T1-T3 and decodes register write enables, bus-mux select and
//   ALU opcode from (state, ir).
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : proc_control_unit_if.master (run, din in; ir, r_in, r_in_a,
//          r_in_g, r_in_h, bus_sel, alu_op, busy, done out)
//
// Build option
//   PROC_CTRL_OVERLAP_FETCH_EN : when defined, a done cycle with run=1 fetches
//   the next instruction directly into T1, except after MOV_IMMEDIATE whose
//   done cycle has din carrying the immediate.
module proc_control_unit (
    input  logic                       clk,
    input  logic                       rst,
    proc_control_unit_if.master        bus
);

    localparam logic [3:0] S_IDLE = 4'b0001;
    localparam logic [3:0] S_T1   = 4'b0010;
    localparam logic [3:0] S_T2   = 4'b0100;
    localparam logic [3:0] S_T3   = 4'b1000;

    localparam logic [2:0] OP_DISP = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_MOVI = 3'b111;

    localparam logic [3:0] SEL_G   = 4'd8;
    localparam logic [3:0] SEL_IMM = 4'd9;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [8:0] ir_q;
    logic       load_ir;

    logic [2:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] rx_onehot;
    logic [2:0] alu_fwd;
    logic       single_step;

    logic [7:0] r_in_c;
    logic       r_in_a_c;
    logic       r_in_g_c;
    logic       r_in_h_c;
    logic [3:0] bus_sel_c;
    logic [2:0] alu_op_c;
    logic       busy_c;
    logic       done_c;

    assign opcode      = ir_q[8:6];
    assign rx          = ir_q[5:3];
    assign ry          = ir_q[2:0];
    assign rx_onehot   = 8'b0000_0001 << rx;
    assign alu_fwd     = (opcode == OP_ADDI) ? OP_ADD : opcode;
    assign single_step = (opcode == OP_DISP) || (opcode == OP_MOVI);

    // Next-state and fetch decision.
    always_comb begin
        state_nxt = state;
        load_ir   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.run) begin
                    state_nxt = S_T1;
                    load_ir   = 1'b1;
                end
            end
            S_T1:    state_nxt = single_step ? S_IDLE : S_T2;
            S_T2:    state_nxt = S_T3;
            S_T3:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
`ifdef PROC_CTRL_OVERLAP_FETCH_EN
        // din carries the immediate during MOV_IMMEDIATE's done cycle, so it
        // cannot double as the next instruction there.
        if (done_c && bus.run && (opcode != OP_MOVI)) begin
            state_nxt = S_T1;
            load_ir   = 1'b1;
        end
`endif
    end

    // Control decode: depends on state and ir only.
    always_comb begin
        r_in_c    = '0;
        r_in_a_c  = 1'b0;
        r_in_g_c  = 1'b0;
        r_in_h_c  = 1'b0;
        bus_sel_c = '0;
        alu_op_c  = '0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            S_T1: begin
                busy_c   = 1'b1;
                alu_op_c = alu_fwd;
                if (opcode == OP_DISP) begin
                    bus_sel_c = {1'b0, rx};
                    r_in_h_c  = 1'b1;
                    done_c    = 1'b1;
                end else if (opcode == OP_MOVI) begin
                    bus_sel_c = SEL_IMM;
                    r_in_c    = rx_onehot;
                    done_c    = 1'b1;
                end else begin
                    bus_sel_c = {1'b0, rx};
                    r_in_a_c  = 1'b1;
                end
            end
            S_T2: begin
                busy_c    = 1'b1;
                alu_op_c  = alu_fwd;
                r_in_g_c  = 1'b1;
                bus_sel_c = (opcode == OP_ADDI) ? SEL_IMM : {1'b0, ry};
            end
            S_T3: begin
                busy_c    = 1'b1;
                alu_op_c  = alu_fwd;
                bus_sel_c = SEL_G;
                r_in_c    = rx_onehot;
                done_c    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            ir_q  <= '0;
        end else begin
            state <= state_nxt;
            if (load_ir) begin
                ir_q <= bus.din;
            end
        end
    end

    assign bus.ir      = ir_q;
    assign bus.r_in    = r_in_c;
    assign bus.r_in_a  = r_in_a_c;
    assign bus.r_in_g  = r_in_g_c;
    assign bus.r_in_h  = r_in_h_c;
    assign bus.bus_sel = bus_sel_c;
    assign bus.alu_op  = alu_op_c;
    assign bus.busy    = busy_c;
    assign bus.done    = done_c;

endmodule

// File: tb/tb_proc_control_unit.sv
// tb_proc_control_unit
//   Scoreboard bench for proc_control_unit. The driver pushes the per-cycle
//   control pattern each instruction should produce; an independent monitor
//   pops one entry per cycle while entries are pending, otherwise expects the
//   idle pattern (all controls 0, ir holding the last fetch).
//   Honours PROC_CTRL_OVERLAP_FETCH_EN for the held-run scenario.
module tb_proc_control_unit;

    typedef struct packed {
        logic       busy;
        logic [8:0] ir;
        logic [7:0] r_in;
        logic       a;
        logic       g;
        logic       h;
        logic [3:0] sel;
        logic [2:0] alu;
        logic       done;
    } obs_t;

    logic clk;
    logic rst;
    proc_control_unit_if bus();

    proc_control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t       exp_q[$];
    logic [8:0] model_ir;
    int         tests;
    int         fails;

    function automatic obs_t mk(input logic b, input logic [8:0] i,
                                input logic [7:0] r, input logic a,
                                input logic g, input logic h,
                                input logic [3:0] s, input logic [2:0] al,
                                input logic d);
        obs_t o;
        o.busy = b; o.ir = i; o.r_in = r; o.a = a; o.g = g; o.h = h;
        o.sel = s; o.alu = al; o.done = d;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(bus.busy, bus.ir, bus.r_in, bus.r_in_a, bus.r_in_g,
                  bus.r_in_h, bus.bus_sel, bus.alu_op, bus.done);
    endfunction

    // Reference: instruction -> sequence of micro-step control patterns.
    // Source operand is routed to A, second operand (register or immediate)
    // into G via the ALU, then G is written back to Rx.
    task automatic push_instr(input logic [8:0] instr);
        int unsigned op, x, y;
        logic [7:0]  dst;
        logic [2:0]  alu;
        op  = instr[8:6];
        x   = instr[5:3];
        y   = instr[2:0];
        dst = 8'(1 << x);
        alu = (op == 2) ? 3'd1 : 3'(op);
        model_ir = instr;
        if (op == 0) begin
            exp_q.push_back(mk(1'b1, instr, 8'h00, 1'b0, 1'b0, 1'b1, 4'(x), alu, 1'b1));
        end else if (op == 7) begin
            exp_q.push_back(mk(1'b1, instr, dst, 1'b0, 1'b0, 1'b0, 4'd9, alu, 1'b1));
        end else begin
            exp_q.push_back(mk(1'b1, instr, 8'h00, 1'b1, 1'b0, 1'b0, 4'(x), alu, 1'b0));
            exp_q.push_back(mk(1'b1, instr, 8'h00, 1'b0, 1'b1, 1'b0,
                               (op == 2) ? 4'd9 : 4'(y), alu, 1'b0));
            exp_q.push_back(mk(1'b1, instr, dst, 1'b0, 1'b0, 1'b0, 4'd8, alu, 1'b1));
        end
    endtask

    task automatic push_idle(input logic [8:0] i);
        exp_q.push_back(mk(1'b0, i, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0));
    endtask

    task automatic check(input string name, input obs_t act, input obs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Monitor: one comparison per cycle, #1 after the rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            check("step", sample(), exp_q.pop_front());
        end else begin
            check("idle", sample(),
                  mk(1'b0, model_ir, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0));
        end
    end

    task automatic drain_check(input string name);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s pending=%0d required=0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    // Issue one instruction from IDLE with run dropped in the done cycle.
    // Called at a falling edge with the DUT idle; returns at a falling edge
    // with the DUT back in IDLE.
    task automatic send(input logic [8:0] instr);
        int unsigned n;
        n = (instr[8:6] == 3'b000 || instr[8:6] == 3'b111) ? 1 : 3;
        bus.run = 1'b1;
        bus.din = instr;
        push_instr(instr);
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clk);
            bus.run = (k < n - 1) ? 1'($urandom) : 1'b0;
            bus.din = 9'($urandom);
        end
        @(negedge clk);
        drain_check("latency");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    localparam logic [8:0] I_MOVI_R2 = 9'b111_010_000;
    localparam logic [8:0] I_ADD_1_2 = 9'b001_001_010;
    localparam logic [8:0] I_ADDI_R5 = 9'b010_101_111;
    localparam logic [8:0] I_SUB_0_7 = 9'b011_000_111;
    localparam logic [8:0] I_DISP_R4 = 9'b000_100_000;

    initial begin
        tests    = 0;
        fails    = 0;
        model_ir = '0;
        rst      = 1'b0;
        bus.run  = 1'b1;
        bus.din  = 9'h1FF;

        // Reset held with run/din active: nothing may be fetched.
        repeat (3) @(negedge clk);
        check("reset", sample(), '0);
        bus.run = 1'b0;
        rst     = 1'b1;
        repeat (5) @(negedge clk);

        // Directed cases.
        send(I_MOVI_R2);
        send(I_ADD_1_2);
        send(I_ADDI_R5);
        send(I_DISP_R4);

        // Held run: SUB R0,R7 -> DISP R4 -> MOV_IMMEDIATE R2.
        bus.run = 1'b1;
        bus.din = I_SUB_0_7;
        push_instr(I_SUB_0_7);
        @(negedge clk); bus.din = 9'($urandom);   // T1
        @(negedge clk); bus.din = 9'($urandom);   // T2
        @(negedge clk); bus.din = I_DISP_R4;      // T3 (done)
`ifndef PROC_CTRL_OVERLAP_FETCH_EN
        push_idle(I_SUB_0_7);
        @(negedge clk);                           // IDLE, refetch
`endif
        push_instr(I_DISP_R4);
        @(negedge clk); bus.din = I_MOVI_R2;      // DISP T1 (done)
`ifndef PROC_CTRL_OVERLAP_FETCH_EN
        push_idle(I_DISP_R4);
        @(negedge clk);
`endif
        push_instr(I_MOVI_R2);
        @(negedge clk); bus.din = 9'h1F0;         // MOVI T1: immediate on din
        push_idle(I_MOVI_R2);                     // never overlaps
        @(negedge clk); bus.run = 1'b0;           // IDLE
        @(negedge clk);
        drain_check("held_run");

        // SUB R0,R7 aborted by reset in T2.
        bus.run = 1'b1;
        bus.din = I_SUB_0_7;
        push_instr(I_SUB_0_7);
        @(negedge clk);                           // T1
        @(negedge clk);                           // T2
        rst      = 1'b0;
        bus.run  = 1'b0;
        exp_q.delete();
        model_ir = '0;
        #1;
        check("abort", sample(), '0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Random instructions with random idle gaps.
        for (int i = 0; i < 200; i++) begin
            send(9'($urandom));
            bus.run = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/proc_control_unit.md
# proc_control_unit

Sequencing controller for the 16-bit processor datapath (R0–R7, A, G, H, 10-input bus multiplexer, external ALU). It fetches a 9-bit instruction from `din` into the instruction register, steps through per-opcode micro-steps T1–T3, and drives each step's register write enables, bus-mux select and ALU opcode. It is a replacement for the tick FSM and the inline control logic, and sits between the external `din`/`run` pins and the datapath.

## Interface
- No parameters; widths fixed (9-bit instruction, 8 GPRs, 4-bit mux select).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `run` in 1: start request; sampled only in IDLE.
- `din` in 9: instruction word at fetch; also the immediate source (via the datapath sign extender) when `bus_sel`=9.
- `ir` out 9: instruction register; `ir[8:6]` opcode, `ir[5:3]` Rx, `ir[2:0]` Ry.
- `r_in` out 8: one-hot GPR write enable.
- `r_in_a`, `r_in_g`, `r_in_h` out 1 each: write enables for A, G and H.
- `bus_sel` out 4: mux select; 0–7 = Rn, 8 = G, 9 = sign-extended `din`, 10–15 unused.
- `alu_op` out 3: opcode forwarded to the ALU; equals `ir[8:6]`, except ADD (001) during ADD_IMMEDIATE.
- `busy` out 1: high in T1–T3.
- `done` out 1: high during the final micro-step of an instruction.

## Operation
- States: IDLE, T1, T2, T3, held as a one-hot register.
- IDLE:
  - If `run`=1: `ir`<=`din`, go to T1.
  - Otherwise stay in IDLE.
- Opcode map: 000 DISP, 001 ADD, 010 ADD_IMMEDIATE, 011 SUB, 100 MUL, 101 SRL, 110 SLL, 111 MOV_IMMEDIATE.
- DISP: T1: `bus_sel`=Rx, `r_in_h`=1, `done`=1, then go to IDLE.
- MOV_IMMEDIATE: T1: `bus_sel`=9, `r_in[Rx]`=1, `done`=1, then go to IDLE. `din` must hold the immediate during T1.
- ADD, SUB, MUL, SRL, SLL:
  - T1: `bus_sel`=Rx, `r_in_a`=1.
  - T2: `bus_sel`=Ry, `r_in_g`=1.
  - T3: `bus_sel`=8, `r_in[Rx]`=1, `done`=1, then go to IDLE.
- ADD_IMMEDIATE: same steps as ADD, except T2 uses `bus_sel`=9. `din` holds the immediate during T2. `ir[2:0]` is ignored.
- All enable, `bus_sel`, `alu_op`, `busy` and `done` outputs are combinational decodes of (state, `ir`) only; they have no path from `run` or `din`.
- In IDLE: all enables 0, `bus_sel`=0, `alu_op`=0.
- Rx=Ry is legal, e.g. ADD R3,R3 doubles R3.
- At most one `r_in` bit is high at any time. It is never high in the same cycle as `r_in_a` or `r_in_g`.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `ir`=0. All outputs are 0 while reset is asserted and after release.
- Reset mid-instruction: the instruction is aborted with no further enables. The datapath registers hold whatever was already written.
- Latency from the `run` sample edge to `done`:
  - DISP and MOV_IMMEDIATE: 1 cycle (`done` in T1).
  - ALU ops: 3 cycles (`done` in T3).
- Throughput without the macro: a new `run` is accepted in the cycle after `done`. Minimum period is 2 cycles (DISP/MOV_IMMEDIATE) or 4 cycles (ALU ops).
- `run` while `busy`=1 is ignored and not queued. Holding `run` high re-fetches each time IDLE is reached.
- Destination writes occur on the clock edge ending the `done` cycle.

## Configuration
- `PROC_CTRL_OVERLAP_FETCH_EN` defined:
  - In a `done` cycle with `run`=1, `ir`<=`din` and the next state is T1, skipping IDLE.
  - Exception: no overlap when the finishing instruction is MOV_IMMEDIATE, because `din` is carrying its immediate. That case returns to IDLE as normal.
  - ALU-op period becomes 3 cycles; DISP period becomes 1 cycle.
- Undefined: `done` always returns to IDLE; `run` is honoured only in IDLE.

## Test plan
- Reset, then release with `run`=0 for 5 cycles -> all outputs 0, `ir`=0, `busy`=0.
- MOV_IMMEDIATE: `run`=1 with `din`=9'b111_010_000, then `din`=9'h1F0 in T1 -> one cycle of `bus_sel`=9, `r_in`=8'b0000_0100, `done`=1; `busy` low the next cycle.
- ADD R1,R2 (`din`=9'b001_001_010):
  - T1: `bus_sel`=1, `r_in_a`.
  - T2: `bus_sel`=2, `r_in_g`, `alu_op`=001.
  - T3: `bus_sel`=8, `r_in`=8'b0000_0010, `done`.
- ADD_IMMEDIATE R5 (`din`=9'b010_101_111), with `din`=9'h1FF in T2 -> T2 shows `bus_sel`=9, `alu_op`=001; T3 shows `r_in`=8'b0010_0000.
- SUB R0,R7 with `run` held high throughout, then `rst` pulsed low mid-T2:
  - Without the reset pulse: second fetch occurs in IDLE (macro off) or in T3 (macro on).
  - With the reset pulse: outputs drop to 0 immediately, `ir`=0, no `r_in` pulse.
- DISP R4 followed by MOV_IMMEDIATE, with the macro on and `run` held -> DISP's `done` cycle loads the new `ir`; MOV_IMMEDIATE's `done` returns to IDLE rather than overlapping.
